// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared CPU definitions (datapath width, divider states, helpers)
//   XLEN         : native datapath width
//   div_state_t  : divider FSM states
//   neg_w/abs_w  : two's-complement negate / absolute value on XLEN bits
package cpu_defs_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] x);
        return ~x + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // abs of the most negative value stays itself, read as an unsigned magnitude
    function automatic logic [XLEN-1:0] abs_w(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? neg_w(x) : x;
    endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in EX
//   clk, resetn        : clock, async active-low reset
//   startE, signedE    : DIV/DIVU in EX, 1 = signed
//   src_aE, src_bE     : dividend, divisor
//   hold_i, flushE     : EX held by other stall sources, exception flush
//   div_stall_o        : stall request into alu_stallE
//   div_valid_o        : quotient/remainder valid
//   quot_o, rem_o      : quotient (LO), remainder (HI)
module div_unit
    import cpu_defs_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] src_aE,
    input  logic [WIDTH-1:0] src_bE,
    input  logic             hold_i,
    input  logic             flushE,
    output logic             div_stall_o,
    output logic             div_valid_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
    logic [WIDTH+1:0] diff;
    logic             neg;

    // q_q starts as |a| and shifts dividend bits out of its top while
    // quotient bits enter at the bottom; r_q[WIDTH] is always 0 here
    assign diff = {r_q, q_q[WIDTH-1]} - {2'b00, b_q};
    assign neg  = diff[WIDTH+1];

    // never a function of hold_i: the hazard unit feeds hold back from alu_stallE
    assign div_stall_o = startE & ~flushE & (state_q != DIV_DONE);
    assign div_valid_o = state_q == DIV_DONE;
    assign quot_o = div_valid_o ? (sq_q ? neg_w(q_q) : q_q) : '0;
    assign rem_o  = div_valid_o ? (sr_q ? neg_w(r_q[WIDTH-1:0]) : r_q[WIDTH-1:0]) : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        b_d     = b_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        unique case (state_q)
            DIV_IDLE: if (startE) begin
                state_d = DIV_BUSY;
                cnt_d   = '0;
                r_d     = '0;
                q_d     = signedE ? abs_w(src_aE) : src_aE;
                b_d     = signedE ? abs_w(src_bE) : src_bE;
                sq_d    = signedE & (src_aE[WIDTH-1] ^ src_bE[WIDTH-1]);
                sr_d    = signedE & src_aE[WIDTH-1];
            end
            DIV_BUSY: begin
                r_d     = neg ? {r_q[WIDTH-1:0], q_q[WIDTH-1]} : diff[WIDTH:0];
                q_d     = {q_q[WIDTH-2:0], ~neg};
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(WIDTH-1) ? DIV_DONE : DIV_BUSY;
            end
            DIV_DONE: state_d = hold_i ? DIV_DONE : DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (flushE) state_d = DIV_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            b_q     <= b_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
        end
    end

    // the pipeline must keep the instruction in EX while busy unless it flushes it
    busy_keeps_start: assert property (@(posedge clk) disable iff (!resetn)
        state_q == DIV_BUSY |-> startE || flushE);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit (directed + random vs. arithmetic model)
module tb_div_unit;
    import cpu_defs_pkg::*;

    logic        clk = 1'b0, resetn = 1'b0, startE = 1'b0, signedE = 1'b0;
    logic        hold_i = 1'b0, flushE = 1'b0;
    logic [31:0] src_aE = '0, src_bE = '0;
    logic        div_stall_o, div_valid_o;
    logic [31:0] quot_o, rem_o;
    int          n_checks = 0, n_fail = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .startE(startE), .signedE(signedE),
        .src_aE(src_aE), .src_bE(src_bE), .hold_i(hold_i), .flushE(flushE),
        .div_stall_o(div_stall_o), .div_valid_o(div_valid_o),
        .quot_o(quot_o), .rem_o(rem_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {rem, quot} from plain arithmetic plus the two architectural corner cases
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] q, r;
        if (b == 0) begin
            q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input bit b2b);
        logic [63:0] e;
        int n;
        e = model(a, b, sgn);
        if (b2b) begin
            @(posedge clk);
            #1;
        end
        src_aE = a; src_bE = b; signedE = sgn; startE = 1'b1;
        #1;
        n = 0;
        while (div_stall_o && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        check({tag, " stall cycles"}, n, 33);
        check({tag, " valid"}, {31'd0, div_valid_o}, 32'd1);
        check({tag, " quot"}, quot_o, e[31:0]);
        check({tag, " rem"}, rem_o, e[63:32]);
    endtask

    task automatic idle_out(input string tag);
        startE = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " idle stall"}, {31'd0, div_stall_o}, 32'd0);
        check({tag, " idle valid"}, {31'd0, div_valid_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, q0, r0;
        logic        rs;
        #1;
        check("reset stall", {31'd0, div_stall_o}, 32'd0);
        check("reset valid", {31'd0, div_valid_o}, 32'd0);
        check("reset quot", quot_o, 32'd0);
        check("reset rem", rem_o, 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        run_div("divu 100/7", 32'd100, 32'd7, 1'b0, 1'b0);
        idle_out("divu 100/7");
        run_div("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        idle_out("div -7/2");
        run_div("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        idle_out("div min/-1");
        run_div("divu 5/0", 32'd5, 32'd0, 1'b0, 1'b0);
        idle_out("divu 5/0");

        src_aE = 32'd100; src_bE = 32'd7; signedE = 1'b0; startE = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1 flushE = 1'b1;
        #1 check("flush stall same cycle", {31'd0, div_stall_o}, 32'd0);
        @(posedge clk);
        #1 flushE = 1'b0; startE = 1'b0;
        #1;
        check("flush idle stall", {31'd0, div_stall_o}, 32'd0);
        check("flush idle valid", {31'd0, div_valid_o}, 32'd0);
        run_div("divu 9/3 after flush", 32'd9, 32'd3, 1'b0, 1'b0);
        idle_out("divu 9/3");

        run_div("divu 1000/33 hold", 32'd1000, 32'd33, 1'b0, 1'b0);
        hold_i = 1'b1;
        q0 = 32'd30; r0 = 32'd10;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold valid", {31'd0, div_valid_o}, 32'd1);
            check("hold stall", {31'd0, div_stall_o}, 32'd0);
            check("hold quot", quot_o, q0);
            check("hold rem", rem_o, r0);
        end
        hold_i = 1'b0;
        idle_out("hold release");

        run_div("b2b divu 20/3", 32'd20, 32'd3, 1'b0, 1'b0);
        run_div("b2b divu 20/6", 32'd20, 32'd6, 1'b0, 1'b1);
        idle_out("b2b");

        src_aE = 32'd20; src_bE = 32'd3; signedE = 1'b0; startE = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #2 resetn = 1'b0; startE = 1'b0;
        #1;
        check("midbusy reset stall", {31'd0, div_stall_o}, 32'd0);
        check("midbusy reset valid", {31'd0, div_valid_o}, 32'd0);
        check("midbusy reset quot", quot_o, 32'd0);
        check("midbusy reset rem", rem_o, 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            run_div($sformatf("rand%0d %h/%h s%0d", i, ra, rb, rs), ra, rb, rs, 1'b0);
            idle_out("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
